// File: rtl/pool_bram_scheduler.sv
// Line-BRAM sequencer for 2x2/stride-2 pooling: even rows are written to BRAM,
// odd rows read back the stored pixel per column and emit vertical {top,bot} pairs.
module pool_bram_scheduler #(
  parameter int SRAM_DEPTH = 1024,
  parameter int DATA_WIDTH = 8,
  localparam int AW = $clog2(SRAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW:0]           cfg_width,
  input  logic [15:0]           cfg_height,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [AW-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_top,
  output logic [DATA_WIDTH-1:0] out_bot,
  output logic [AW-1:0]         out_col,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [1:0]            dbg_state
);

  // Handshake: a pixel transfers on a rising edge where in_valid && in_ready;
  // the source must hold in_data stable while in_valid is high and not ready.
  // The output side has no ready: downstream takes every out_valid cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ROW = 2'd1,
    RD_ROW = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(SRAM_DEPTH);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  state_e                state_q, state_d;
  logic [AW:0]           width_q, width_d;
  logic [15:0]           height_q, height_d;
  logic [AW-1:0]         col_q, col_d;
  logic [15:0]           row_q, row_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_bot_q, out_bot_d;
  logic [AW-1:0]         out_col_q, out_col_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] top_hold_q, top_hold_d;
  logic                  cfg_err_q, cfg_err_d;

  logic accept;
  logic last_col;
  logic last_pair_row;
  logic cfg_ok;

  assign in_ready      = (state_q == WR_ROW) || (state_q == RD_ROW);
  assign accept        = in_valid && in_ready;
  assign last_col      = ({1'b0, col_q} == (width_q - ONE_W));
  // An odd final row is never consumed, so the frame ends on the last even/odd pair.
  assign last_pair_row = (row_q == ((height_q & 16'hFFFE) - 16'd1));
  assign cfg_ok        = (cfg_width != '0) && (cfg_width <= DEPTH_W) && (cfg_height >= 16'd2);

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = 1'b0;
    out_bot_d   = out_bot_q;
    out_col_d   = out_col_q;
    last_d      = 1'b0;
    cfg_err_d   = 1'b0;
    // Freeze the BRAM read word while it is presented so out_top holds afterwards.
    top_hold_d  = out_valid_q ? bram_dout : top_hold_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            width_d  = cfg_width;
            height_d = cfg_height;
            col_d    = '0;
            row_d    = '0;
            state_d  = WR_ROW;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      WR_ROW: begin
        if (accept) begin
          if (last_col) begin
            col_d   = '0;
            row_d   = row_q + 16'd1;
            state_d = RD_ROW;
          end else begin
            col_d = col_q + ONE_A;
          end
        end
      end
      RD_ROW: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_bot_d   = in_data;
          out_col_d   = col_q;
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 16'd1;
            if (last_pair_row) begin
              last_d  = 1'b1;
              state_d = DRAIN;
            end else begin
              state_d = WR_ROW;
            end
          end else begin
            col_d = col_q + ONE_A;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_bot_q   <= '0;
      out_col_q   <= '0;
      last_q      <= 1'b0;
      top_hold_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_bot_q   <= out_bot_d;
      out_col_q   <= out_col_d;
      last_q      <= last_d;
      top_hold_q  <= top_hold_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bram_en   = accept;
  assign bram_we   = accept && (state_q == WR_ROW);
  assign bram_addr = col_q;
  assign bram_din  = bram_we ? in_data : '0;

  // BRAM data arrives the cycle after the read enable, aligned with out_valid.
  assign out_valid = out_valid_q;
  assign out_top   = out_valid_q ? bram_dout : top_hold_q;
  assign out_bot   = out_bot_q;
  assign out_col   = out_col_q;
  assign out_last  = last_q;
  assign done      = last_q;
  assign busy      = (state_q != IDLE);
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pool_bram_scheduler.sv
// Bench for pool_bram_scheduler: randomized frames against a row-buffer pair model,
// external 1-cycle BRAM model, plus literal pair checks for small known frames.
module tb_pool_bram_scheduler;
  localparam int DEPTH = 1024;
  localparam int DW    = 8;
  localparam int AW    = 10;

  typedef struct packed {
    logic [DW-1:0] top;
    logic [DW-1:0] bot;
    logic [AW-1:0] col;
    logic          last;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   cfg_width = '0;
  logic [15:0]   cfg_height = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout = '0;
  logic          out_valid;
  logic [DW-1:0] out_top, out_bot;
  logic [AW-1:0] out_col;
  logic          out_last, busy, done, cfg_err;
  logic [1:0]    dbg_state;

  pool_bram_scheduler #(.SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .out_valid(out_valid), .out_top(out_top), .out_bot(out_bot),
    .out_col(out_col), .out_last(out_last), .busy(busy), .done(done), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External single-port BRAM, 1-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout <= mem[bram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  pair_t exp_q[$];
  int    exp_cyc_q[$];
  pair_t log_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : compare
    pair_t e;
    if (rst) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        check("out_valid", 64'(out_valid), 64'd1);
        check("pair", 64'({out_top, out_bot, out_col, out_last}), 64'(e));
        check("done_eq_last", 64'(done), 64'(e.last));
        log_q.push_back({out_top, out_bot, out_col, out_last});
      end else begin
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_last_done", 64'({out_last, done}), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_pct < 0 means exactly one idle cycle before every pixel.
  task automatic run_frame(input int w, input int h, input bit seq, input int gap_pct,
                           input int abort_col, input bit poke_start);
    logic [DW-1:0] row_buf [DEPTH];
    logic [DW-1:0] val;
    int rows;
    int n;
    pair_t p;
    rows = h & ~1;
    n = 0;
    log_q.delete();
    cfg_width = (AW+1)'(w);
    cfg_height = 16'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    if (poke_start) begin
      cfg_width = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      check("start_while_busy_no_err", 64'({cfg_err, busy}), 64'b01);
    end
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < w; c++) begin
        if (abort_col >= 0 && r == 1 && c == abort_col) begin
          in_valid = 1'b0;
          return;
        end
        while ((gap_pct < 0) ? 1'b1 : ($urandom_range(99) < gap_pct)) begin
          in_valid = 1'b0;
          #1;
          check("gap_no_bram_en", 64'(bram_en), 64'd0);
          tick();
          if (gap_pct < 0) break;
        end
        n++;
        val = seq ? DW'(n) : DW'($urandom_range(255));
        in_valid = 1'b1;
        in_data = val;
        #1;
        check("in_ready", 64'(in_ready), 64'd1);
        check("bram_en", 64'(bram_en), 64'd1);
        check("bram_we", 64'(bram_we), (r % 2 == 0) ? 64'd1 : 64'd0);
        check("bram_addr", 64'(bram_addr), 64'(c));
        if (r % 2 == 0) begin
          check("bram_din", 64'(bram_din), 64'(val));
          row_buf[c] = val;
        end else begin
          p.top  = row_buf[c];
          p.bot  = val;
          p.col  = AW'(c);
          p.last = (r == rows - 1) && (c == w - 1);
          exp_q.push_back(p);
          exp_cyc_q.push_back(cyc + 1);
        end
        tick();
      end
    end
    in_valid = 1'b0;
    check("drain_busy", 64'({busy, in_ready}), 64'b10);
    tick();
    check("idle_after_drain", 64'({busy, in_ready}), 64'b00);
    check("all_pairs_seen", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic bad_cfg(input int w, input int h);
    cfg_width = (AW+1)'(w);
    cfg_height = 16'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_err_pulse", 64'({cfg_err, busy}), 64'b10);
    tick();
    check("cfg_err_clears", 64'({cfg_err, busy}), 64'b00);
  endtask

  task automatic check_pair(input string name, input int idx, input pair_t req);
    pair_t act;
    act = (idx < log_q.size()) ? log_q[idx] : '0;
    check(name, 64'(act), 64'(req));
  endtask

  task automatic check_t1_pairs();
    check("t1_count", 64'(log_q.size()), 64'd4);
    check_pair("t1_pair0", 0, {8'd1, 8'd5, 10'd0, 1'b0});
    check_pair("t1_pair2", 2, {8'd3, 8'd7, 10'd2, 1'b0});
    check_pair("t1_pair3", 3, {8'd4, 8'd8, 10'd3, 1'b1});
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    #2;
    check("reset_outputs", 64'({in_ready, bram_en, bram_we, bram_addr, bram_din, out_valid,
          out_top, out_bot, out_col, out_last, busy, done, cfg_err}), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // T1
    run_frame(4, 2, 1'b1, 0, -1, 1'b0);
    check_t1_pairs();
    tick();

    // T2: alternating valid, second pair row reads rewritten BRAM words
    run_frame(3, 4, 1'b1, -1, -1, 1'b1);
    check("t2_count", 64'(log_q.size()), 64'd6);
    check_pair("t2_pair3", 3, {8'd7, 8'd10, 10'd0, 1'b0});
    check_pair("t2_pair5", 5, {8'd9, 8'd12, 10'd2, 1'b1});
    tick();

    // T3: full-depth row
    run_frame(1024, 2, 1'b0, 0, -1, 1'b0);
    check("t3_count", 64'(log_q.size()), 64'd1024);
    tick();

    // T4
    bad_cfg(0, 2);
    bad_cfg(1025, 2);
    bad_cfg(4, 1);

    // T5: odd height, fifth row refused
    run_frame(2, 5, 1'b0, 20, -1, 1'b0);
    check("t5_count", 64'(log_q.size()), 64'd4);
    in_valid = 1'b1;
    in_data = 8'hAA;
    #1;
    check("t5_row5_refused", 64'({in_ready, bram_en}), 64'd0);
    tick();
    in_valid = 1'b0;
    tick();

    // width 1 and a few random frames
    run_frame(1, 6, 1'b0, 30, -1, 1'b0);
    check("w1_count", 64'(log_q.size()), 64'd3);
    tick();
    for (int k = 0; k < 4; k++) begin
      int w, h;
      w = $urandom_range(1, 40);
      h = $urandom_range(2, 9);
      run_frame(w, h, 1'b0, 25, -1, 1'b0);
      check("rand_count", 64'(log_q.size()), 64'(w * (h / 2)));
      tick();
    end

    // T6: asynchronous reset in RD_ROW at col 2
    run_frame(4, 2, 1'b1, 0, 2, 1'b0);
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check("t6_async_reset", 64'({in_ready, bram_en, bram_we, bram_addr, bram_din, out_valid,
          out_top, out_bot, out_col, out_last, busy, done, cfg_err}), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    run_frame(4, 2, 1'b1, 0, -1, 1'b0);
    check_t1_pairs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
